// File: rtl/vend_pkg.sv
// Shared types and constants for the vend dispense controller.
package vend_pkg;

  localparam int unsigned CHG_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SODA,
    ST_GAP,
    ST_COIN,
    ST_FAULT
  } state_t;

  localparam logic [CHG_W-1:0] CHG_NONE = 3'd0;
  localparam logic [CHG_W-1:0] CHG_5    = 3'd1;
  localparam logic [CHG_W-1:0] CHG_10   = 3'd2;
  localparam logic [CHG_W-1:0] CHG_15   = 3'd3;
  localparam logic [CHG_W-1:0] CHG_20   = 3'd4;

endpackage

// File: rtl/vend_if.sv
// Vend pulse, motor handshakes and status flags between the vending FSM/motors and the dispense controller.
interface vend_if;

  logic                       i_soda;
  logic [vend_pkg::CHG_W-1:0] i_change;
  logic                       i_soda_ack;
  logic                       i_coin_ack;
  logic                       o_soda_req;
  logic                       o_coin_req;
  logic                       o_busy;
  logic                       o_full;
  logic                       o_drop;
  logic                       o_fault;

  modport master (
    output i_soda, i_change, i_soda_ack, i_coin_ack,
    input  o_soda_req, o_coin_req, o_busy, o_full, o_drop, o_fault
  );

  modport slave (
    input  i_soda, i_change, i_soda_ack, i_coin_ack,
    output o_soda_req, o_coin_req, o_busy, o_full, o_drop, o_fault
  );

endinterface

// File: rtl/vend_fifo.sv
// Show-ahead synchronous FIFO holding the change code of each pending vend.
module vend_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [W-1:0]                 wdata,
  input  logic                         rd,
  output logic [W-1:0]                 head_c,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full_c,
  output logic                         empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign head_c  = mem[rptr];
  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Queues vend pulses and sequences soda then nickel motors through req/ack
// handshakes with inter-request gaps and a per-request timeout fault.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic  i_clk,
  input  logic  i_reset,
  vend_if.slave bus
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT+1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES+1);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [CHG_W-1:0]   coin_cnt, coin_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [CHG_W-1:0]   head_c;
  logic               full_c, empty_c;
  logic               pop, wr;

  vend_fifo #(.DEPTH(DEPTH), .W(CHG_W)) u_fifo (
    .clk     (i_clk),
    .reset   (i_reset),
    .wr      (wr),
    .wdata   (bus.i_change),
    .rd      (pop),
    .head_c  (head_c),
    .count   (count),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // A same-cycle pop frees the slot, so a full FIFO still accepts a vend.
  assign wr        = bus.i_soda && (state != ST_FAULT) && (!full_c || pop);
  assign count_nxt = count + CNT_W'(wr) - CNT_W'(pop);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    gap_nxt   = gap_cnt;
    coin_nxt  = coin_cnt;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty_c) begin
          pop       = 1'b1;
          coin_nxt  = head_c;
          timer_nxt = '0;
          state_nxt = ST_SODA;
        end
      end
      ST_SODA: begin
        if (bus.i_soda_ack) begin
          gap_nxt   = GAP_W'(GAP_CYCLES);
          state_nxt = ST_GAP;
        end else if (timer == TMR_W'(TIMEOUT-1)) begin
          state_nxt = ST_FAULT;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt <= GAP_W'(1)) begin
          if (coin_cnt != '0) begin
            timer_nxt = '0;
            state_nxt = ST_COIN;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end
      ST_COIN: begin
        if (bus.i_coin_ack) begin
          if (coin_cnt != '0) coin_nxt = coin_cnt - CHG_W'(1);
          gap_nxt   = GAP_W'(GAP_CYCLES);
          state_nxt = ST_GAP;
        end else if (timer == TMR_W'(TIMEOUT-1)) begin
          state_nxt = ST_FAULT;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state so they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      timer          <= '0;
      gap_cnt        <= '0;
      coin_cnt       <= '0;
      bus.o_soda_req <= 1'b0;
      bus.o_coin_req <= 1'b0;
      bus.o_busy     <= 1'b0;
      bus.o_full     <= 1'b0;
      bus.o_drop     <= 1'b0;
      bus.o_fault    <= 1'b0;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      gap_cnt        <= gap_nxt;
      coin_cnt       <= coin_nxt;
      bus.o_soda_req <= (state_nxt == ST_SODA);
      bus.o_coin_req <= (state_nxt == ST_COIN);
      bus.o_busy     <= (state_nxt != ST_IDLE) || (count_nxt != '0);
      bus.o_full     <= (count_nxt == CNT_W'(DEPTH)) || (state_nxt == ST_FAULT);
      bus.o_drop     <= bus.i_soda && !wr;
      bus.o_fault    <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: vector table plus multi-cycle corner sequences.
module tb_vend_dispense_ctrl;
  import vend_pkg::*;

  // Expected output word: {soda_req, coin_req, busy, full, drop, fault}
  typedef struct {
    string       name;
    logic        rst;
    logic        soda;
    logic [2:0]  chg;
    logic        sack;
    logic        cack;
    logic [5:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  vend_if bus();

  vend_dispense_ctrl #(.DEPTH(4), .GAP_CYCLES(2), .TIMEOUT(16)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  function automatic logic [5:0] outs();
    return {bus.o_soda_req, bus.o_coin_req, bus.o_busy, bus.o_full, bus.o_drop, bus.o_fault};
  endfunction

  function automatic void add(input string nm, input logic r, input logic s, input logic [2:0] c,
                              input logic sa, input logic ca, input logic [5:0] e);
    vec_t v;
    v.name = nm; v.rst = r; v.soda = s; v.chg = c; v.sack = sa; v.cack = ca; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic r, input logic s, input logic [2:0] c, input logic sa, input logic ca);
    rst            = r;
    bus.i_soda     = s;
    bus.i_change   = c;
    bus.i_soda_ack = sa;
    bus.i_coin_ack = ca;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (soda_req coin_req busy full drop fault)", nm, act, exp);
    end
  endtask

  initial begin
    // Test 1: change 3, acks 3 cycles after each req rise
    add("t1_reset", 1, 0, 0, 0, 0, 6'b000000);
    add("t1_vend",  0, 1, 3, 0, 0, 6'b001000);
    add("t1_soda",  0, 0, 0, 0, 0, 6'b101000);
    add("t1_soda",  0, 0, 0, 0, 0, 6'b101000);
    add("t1_soda",  0, 0, 0, 0, 0, 6'b101000);
    add("t1_sack",  0, 0, 0, 1, 0, 6'b001000);
    add("t1_gap",   0, 0, 0, 0, 0, 6'b001000);
    for (int k = 0; k < 3; k++) begin
      add($sformatf("t1_coin%0d_rise", k), 0, 0, 0, 0, 0, 6'b011000);
      add($sformatf("t1_coin%0d_hold", k), 0, 0, 0, 0, 0, 6'b011000);
      add($sformatf("t1_coin%0d_hold", k), 0, 0, 0, 0, 0, 6'b011000);
      add($sformatf("t1_coin%0d_ack",  k), 0, 0, 0, 0, 1, 6'b001000);
      add($sformatf("t1_coin%0d_gap",  k), 0, 0, 0, 0, 0, 6'b001000);
    end
    add("t1_idle",  0, 0, 0, 0, 0, 6'b000000);
    add("t1_idle2", 0, 0, 0, 0, 0, 6'b000000);
    // Test 2: no change owed
    add("t2_reset", 1, 0, 0, 0, 0, 6'b000000);
    add("t2_vend",  0, 1, 0, 0, 0, 6'b001000);
    add("t2_soda",  0, 0, 0, 0, 0, 6'b101000);
    add("t2_sack",  0, 0, 0, 1, 0, 6'b001000);
    add("t2_gap",   0, 0, 0, 0, 0, 6'b001000);
    add("t2_idle",  0, 0, 0, 0, 0, 6'b000000);
    add("t2_nocoin",0, 0, 0, 0, 1, 6'b000000);
    add("t2_nocoin",0, 0, 0, 0, 0, 6'b000000);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].soda, tbl[i].chg, tbl[i].sack, tbl[i].cack);
      check(tbl[i].name, outs(), tbl[i].exp);
    end

    // Test 3: acks held low, six vends two cycles apart
    step(1, 0, 0, 0, 0);
    for (int v = 0; v < 6; v++) begin
      step(0, 1, 1, 0, 0);
      check($sformatf("t3_vend%0d", v), outs(),
            {1'(v > 0), 1'b0, 1'b1, 1'(v >= 4), 1'(v == 5), 1'b0});
      step(0, 0, 0, 0, 0);
      check($sformatf("t3_after%0d", v), outs(), {1'b1, 1'b0, 1'b1, 1'(v >= 4), 1'b0, 1'b0});
    end

    // Test 4: soda request never acknowledged
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    check("t4_vend", outs(), 6'b001000);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 0, 0, 0);
      check($sformatf("t4_req%0d", i), outs(), 6'b101000);
    end
    step(0, 0, 0, 0, 0);
    check("t4_fault", outs(), 6'b001101);
    step(0, 1, 2, 0, 0);
    check("t4_drop", outs(), 6'b001111);
    step(0, 0, 0, 1, 1);
    check("t4_sticky", outs(), 6'b001101);
    step(0, 0, 0, 0, 0);
    check("t4_sticky2", outs(), 6'b001101);
    step(1, 0, 0, 0, 0);
    check("t4_reset", outs(), 6'b000000);

    // Test 5: reset in COIN with two nickels owed and two vends queued
    step(1, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0); check("t5_vend",  outs(), 6'b001000);
    step(0, 1, 1, 0, 0); check("t5_q1",    outs(), 6'b101000);
    step(0, 1, 1, 0, 0); check("t5_q2",    outs(), 6'b101000);
    step(0, 0, 0, 1, 0); check("t5_sack",  outs(), 6'b001000);
    step(0, 0, 0, 0, 0); check("t5_gap",   outs(), 6'b001000);
    step(0, 0, 0, 0, 0); check("t5_coin1", outs(), 6'b011000);
    step(0, 0, 0, 0, 1); check("t5_cack",  outs(), 6'b001000);
    step(0, 0, 0, 0, 0); check("t5_gap2",  outs(), 6'b001000);
    step(0, 0, 0, 0, 0); check("t5_coin2", outs(), 6'b011000);
    step(1, 0, 0, 0, 0); check("t5_reset", outs(), 6'b000000);
    step(0, 0, 0, 0, 1); check("t5_stale_ack", outs(), 6'b000000);
    step(0, 0, 0, 0, 0); check("t5_empty", outs(), 6'b000000);
    step(0, 0, 0, 0, 0); check("t5_empty2", outs(), 6'b000000);

    // Test 6: vend arrives on the edge IDLE pops a full FIFO
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0); check("t6_v0", outs(), 6'b001000);
    step(0, 1, 0, 0, 0); check("t6_v1", outs(), 6'b101000);
    step(0, 1, 0, 0, 0); check("t6_v2", outs(), 6'b101000);
    step(0, 1, 0, 0, 0); check("t6_v3", outs(), 6'b101000);
    step(0, 1, 0, 0, 0); check("t6_full", outs(), 6'b101100);
    step(0, 0, 0, 1, 0); check("t6_sack", outs(), 6'b001100);
    step(0, 0, 0, 0, 0); check("t6_gap",  outs(), 6'b001100);
    step(0, 0, 0, 0, 0); check("t6_idle_full", outs(), 6'b001100);
    step(0, 1, 2, 0, 0); check("t6_pop_wr", outs(), 6'b101100);
    step(0, 0, 0, 0, 0); check("t6_no_drop", outs(), 6'b101100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
